// File: rtl/frog_pkg.sv
// Shared constants for the frog LFSR bank: step-mode encoding and default geometry.
package frog_pkg;

  localparam logic MODE_FIB = 1'b0;  // feedback parity shifted into bit 0
  localparam logic MODE_GAL = 1'b1;  // bit N-1 conditionally XORs the tap program

  localparam int unsigned DefaultN        = 16;
  localparam int unsigned DefaultChannels = 4;

endpackage

// File: rtl/frog_lfsr_chan.sv
// One LFSR channel: serially loaded tap program and seed, Fibonacci/Galois stepping and
// period measurement against the loaded seed.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_en_i           shift program_i/seed_i in (LSB first); clears the measurement
//   step_i              advance the LFSR one step (ignored while load_en_i)
//   mode_i              MODE_FIB or MODE_GAL
//   program_i, seed_i   serial tap-program and seed bits
//   state_o             current LFSR state
//   period_o            measured period, 0 until valid or stuck
//   period_valid_o      state has returned to seed
//   stuck_o             no return to seed within 2^N steps
module frog_lfsr_chan
  import frog_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_en_i,
  input  logic         step_i,
  input  logic         mode_i,
  input  logic         program_i,
  input  logic         seed_i,
  output logic [N-1:0] state_o,
  output logic [N:0]   period_o,
  output logic         period_valid_o,
  output logic         stuck_o
);

  localparam logic [N:0] CountFull = {1'b1, {N{1'b0}}};

  logic [N-1:0] prog_q, prog_d;
  logic [N-1:0] seed_q, seed_d;
  logic [N-1:0] state_q, state_d;
  logic [N:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic         stuck_q, stuck_d;

  logic [N-1:0] next_state;
  logic [N:0]   count_inc;

  always_comb begin
    if (mode_i == MODE_GAL) begin
      next_state = {state_q[N-2:0], 1'b0} ^ (state_q[N-1] ? prog_q : '0);
    end else begin
      next_state = {state_q[N-2:0], ^(state_q & prog_q)};
    end
    count_inc = count_q + {{N{1'b0}}, 1'b1};
  end

  always_comb begin
    prog_d  = prog_q;
    seed_d  = seed_q;
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    stuck_d = stuck_q;
    if (load_en_i) begin
      prog_d  = {program_i, prog_q[N-1:1]};
      seed_d  = {seed_i, seed_q[N-1:1]};
      state_d = {seed_i, state_q[N-1:1]};
      count_d = '0;
      valid_d = 1'b0;
      stuck_d = 1'b0;
    end else if (step_i) begin
      state_d = next_state;
      // count freezes once either flag is set, so it doubles as the latched period
      if (!valid_q && !stuck_q) begin
        count_d = count_inc;
        if (next_state == seed_q) begin
          valid_d = 1'b1;
        end else if (count_inc == CountFull) begin
          stuck_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prog_q  <= '0;
      seed_q  <= '0;
      state_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      prog_q  <= prog_d;
      seed_q  <= seed_d;
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  assign state_o        = state_q;
  assign period_o       = (valid_q || stuck_q) ? count_q : '0;
  assign period_valid_o = valid_q;
  assign stuck_o        = stuck_q;

endmodule

// File: rtl/frog_lfsr_bank.sv
// Bank of CHANNELS independently programmable LFSRs with per-channel period measurement.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_i, ch_sel_i    serial load of the addressed channel; load freezes every channel
//   program_i, seed_i   serial tap-program and seed bits, LSB first
//   run_i, mode_i       step all channels (when not loading), Fibonacci/Galois select
//   out_o               MSB of every channel
//   state_out_o, period_o, period_valid_o, stuck_o   readout of channel ch_sel_i (0 if absent)
module frog_lfsr_bank
  import frog_pkg::*;
#(
  parameter int unsigned N          = DefaultN,
  parameter int unsigned CHANNELS   = DefaultChannels,
  localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CW-1:0]       ch_sel_i,
  input  logic                program_i,
  input  logic                seed_i,
  input  logic                run_i,
  input  logic                mode_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [N-1:0]        state_out_o,
  output logic [N:0]          period_o,
  output logic                period_valid_o,
  output logic                stuck_o
);

  logic [N-1:0] state_a  [CHANNELS];
  logic [N:0]   period_a [CHANNELS];
  logic         valid_a  [CHANNELS];
  logic         stuck_a  [CHANNELS];

  logic step;
  assign step = run_i && !load_i;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    frog_lfsr_chan #(
      .N(N)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .load_en_i      (load_i && (ch_sel_i == CW'(c))),
      .step_i         (step),
      .mode_i         (mode_i),
      .program_i      (program_i),
      .seed_i         (seed_i),
      .state_o        (state_a[c]),
      .period_o       (period_a[c]),
      .period_valid_o (valid_a[c]),
      .stuck_o        (stuck_a[c])
    );
    assign out_o[c] = state_a[c][N-1];
  end

  always_comb begin
    state_out_o    = '0;
    period_o       = '0;
    period_valid_o = 1'b0;
    stuck_o        = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch_sel_i == CW'(c)) begin
        state_out_o    = state_a[c];
        period_o       = period_a[c];
        period_valid_o = valid_a[c];
        stuck_o        = stuck_a[c];
      end
    end
  end

endmodule

// File: tb/tb_frog_lfsr_bank.sv
// Bench for frog_lfsr_bank: directed stimulus pushes expected readouts into a queue, a monitor
// pops and compares them on the falling clock edge.
module tb_frog_lfsr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic        program_bit = 1'b0;
  logic        seed_bit = 1'b0;
  logic        run = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  out;
  logic [15:0] state_out;
  logic [16:0] period;
  logic        period_valid;
  logic        stuck;

  always #5 clk = ~clk;

  frog_lfsr_bank #(
    .N(16),
    .CHANNELS(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_i         (load),
    .ch_sel_i       (ch_sel),
    .program_i      (program_bit),
    .seed_i         (seed_bit),
    .run_i          (run),
    .mode_i         (mode),
    .out_o          (out),
    .state_out_o    (state_out),
    .period_o       (period),
    .period_valid_o (period_valid),
    .stuck_o        (stuck)
  );

  typedef struct {
    string       name;
    logic        chk_st;
    logic [15:0] st;
    logic [16:0] per;
    logic        pv;
    logic        stk;
    logic [3:0]  ov;
    logic [3:0]  om;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ((e.chk_st && state_out !== e.st) || period !== e.per || period_valid !== e.pv ||
          stuck !== e.stk || (out & e.om) !== (e.ov & e.om)) begin
        errors++;
        $display("FAIL %s: got state=%h period=%h valid=%b stuck=%b out=%b ; want state=%h(chk %b) period=%h valid=%b stuck=%b out=%b mask=%b",
                 e.name, state_out, period, period_valid, stuck, out,
                 e.st, e.chk_st, e.per, e.pv, e.stk, e.ov, e.om);
      end
    end
  end

  // Select a channel, queue its expected readout and let the monitor consume it.
  task automatic expect_rd(input string name, input logic [1:0] ch, input logic chk_st,
                           input logic [15:0] st, input logic [16:0] per, input logic pv,
                           input logic stk, input logic [3:0] ov, input logic [3:0] om);
    exp_t e;
    ch_sel = ch;
    e.name = name; e.chk_st = chk_st; e.st = st; e.per = per;
    e.pv = pv; e.stk = stk; e.ov = ov; e.om = om;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_steps(input int n);
    run = 1'b1;
    cyc(n);
    run = 1'b0;
  endtask

  task automatic load_ch(input logic [1:0] ch, input logic [15:0] prog, input logic [15:0] sd);
    logic [15:0] p;
    logic [15:0] s;
    p = prog;
    s = sd;
    ch_sel = ch;
    load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      program_bit = p[i];
      seed_bit    = s[i];
      cyc(1);
    end
    load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, load, step, asynchronous reset between edges
    cyc(2);
    expect_rd("reset_all_zero", 2'd0, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    rst = 1'b0;
    load_ch(2'd0, 16'hB400, 16'hFFFF);
    expect_rd("ch0_loaded", 2'd0, 1'b1, 16'hFFFF, 17'h0, 1'b0, 1'b0, 4'b0001, 4'b1111);
    run_steps(5);
    expect_rd("ch0_fib_5_steps", 2'd0, 1'b1, 16'hFFE0, 17'h0, 1'b0, 1'b0, 4'b0001, 4'b1111);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_rd("async_reset", 2'd0, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    rst = 1'b0;

    // 2, 4, 5: Fibonacci maximal length, rotate, all-zero program run together
    mode = 1'b0;
    load_ch(2'd0, 16'hB400, 16'hFFFF);
    load_ch(2'd2, 16'h8000, 16'h0001);
    load_ch(2'd3, 16'h0000, 16'h0001);
    run_steps(16);
    expect_rd("ch2_rotate_period", 2'd2, 1'b1, 16'h0001, 17'd16, 1'b1, 1'b0, 4'b0000, 4'b1100);
    expect_rd("ch3_zero_after_16", 2'd3, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b1000);
    run_steps(65535 - 16);
    expect_rd("ch0_fib_period", 2'd0, 1'b1, 16'hFFFF, 17'h0FFFF, 1'b1, 1'b0, 4'b0001, 4'b1001);
    expect_rd("ch3_not_yet_stuck", 2'd3, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b1000);
    run_steps(1);
    expect_rd("ch3_stuck", 2'd3, 1'b1, 16'h0000, 17'h10000, 1'b0, 1'b1, 4'b0000, 4'b1000);
    expect_rd("ch0_period_frozen", 2'd0, 1'b1, 16'hFFFE, 17'h0FFFF, 1'b1, 1'b0, 4'b0001, 4'b0001);
    expect_rd("ch2_after_65536", 2'd2, 1'b1, 16'h0001, 17'd16, 1'b1, 1'b0, 4'b0000, 4'b0100);

    // 3: Galois channel load leaves ch0 alone, then Galois stepping
    load_ch(2'd1, 16'h6801, 16'h0001);
    expect_rd("ch0_untouched_by_ch1", 2'd0, 1'b1, 16'hFFFE, 17'h0FFFF, 1'b1, 1'b0, 4'b0001, 4'b0001);
    expect_rd("ch1_loaded", 2'd1, 1'b1, 16'h0001, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b0010);
    load_ch(2'd2, 16'h0001, 16'h0001);
    mode = 1'b1;
    run_steps(15);
    expect_rd("ch1_gal_15", 2'd1, 1'b1, 16'h8000, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0010);
    run_steps(1);
    expect_rd("ch1_gal_16", 2'd1, 1'b1, 16'h6801, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b0010);
    run_steps(1);
    expect_rd("ch1_gal_17", 2'd1, 1'b1, 16'hD002, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0010);
    run_steps(1);
    expect_rd("ch1_gal_18", 2'd1, 1'b1, 16'hC805, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0010);
    expect_rd("ch2_gal_rotate", 2'd2, 1'b1, 16'h0004, 17'd16, 1'b1, 1'b0, 4'b0000, 4'b0100);
    expect_rd("ch0_flag_sticky", 2'd0, 1'b0, 16'h0000, 17'h0FFFF, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // 4: zero seed matches after a single step
    mode = 1'b0;
    load_ch(2'd2, 16'h8000, 16'h0000);
    expect_rd("ch2_zero_seed_loaded", 2'd2, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b0100);
    run_steps(1);
    expect_rd("ch2_period_1", 2'd2, 1'b1, 16'h0000, 17'd1, 1'b1, 1'b0, 4'b0000, 4'b0100);
    expect_rd("ch1_fib_step", 2'd1, 1'b1, 16'h900B, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0010);

    // 6: load has priority over run, then hold with run low
    ch_sel = 2'd3;
    program_bit = 1'b0;
    seed_bit = 1'b0;
    load = 1'b1;
    run = 1'b1;
    cyc(4);
    load = 1'b0;
    run = 1'b0;
    expect_rd("load_run_no_step", 2'd1, 1'b1, 16'h900B, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0110);
    expect_rd("ch3_flags_cleared", 2'd3, 1'b1, 16'h0000, 17'h0, 1'b0, 1'b0, 4'b0000, 4'b1000);
    expect_rd("ch2_untouched", 2'd2, 1'b1, 16'h0000, 17'd1, 1'b1, 1'b0, 4'b0000, 4'b0100);
    cyc(10);
    expect_rd("hold_run_low", 2'd1, 1'b1, 16'h900B, 17'h0, 1'b0, 1'b0, 4'b0010, 4'b0110);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
